// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//   One shared clock prescaler feeding NCH independent tick channels. Each
//   channel emits single-cycle enable pulses in the main clock domain at its
//   own programmable rate (a whole number of base ticks). No derived clocks.
//   Period updates go through a valid/ready request and are applied only on a
//   base-tick boundary (or at once while the prescaler is frozen), so a
//   channel never sees a partial or glitched period.
//
// Ports
//   clock       in   1    system clock, all logic on posedge
//   reset       in   1    synchronous, active-high
//   enable      in   1    1 = prescaler runs, 0 = prescaler frozen
//   ch_en       in   NCH  per-channel run enable
//   cfg_valid   in   1    config request
//   cfg_ready   out  1    request accepted when cfg_valid & cfg_ready
//   cfg_ch      in   CW   target channel (out-of-range index ignored, still acked)
//   cfg_period  in   PW   new period in base ticks (0 = channel silent)
//   cfg_ack     out  1    one-cycle pulse once the config has been applied
//   base_tick   out  1    one-cycle pulse per prescaler wrap
//   tick        out  NCH  per-channel one-cycle pulses
// -----------------------------------------------------------------------------
module tick_scheduler #(
  parameter int BASE_DIV   = 50000,
  parameter int NCH        = 4,
  parameter int PW         = 10,
  parameter int RST_PERIOD = 0,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [NCH-1:0]  ch_en,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [PW-1:0]   cfg_period,
  output logic            cfg_ack,
  output logic            base_tick,
  output logic [NCH-1:0]  tick
);

  localparam int DW = $clog2(BASE_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  logic [DW-1:0]  r_pre;
  logic           r_base;
  logic           w_wrap;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_latch;
  logic           w_apply;
  logic           r_ready;
  logic           r_ack;
  logic [CW-1:0]  r_lat_ch;
  logic [PW-1:0]  r_lat_per;
  logic [NCH-1:0] w_sel;

  logic [PW-1:0]  r_period [NCH];
  logic [PW-1:0]  r_cnt    [NCH];
  logic [NCH-1:0] r_tick;

  // Prescaler wrap edge: the only edge on which channels are evaluated.
  assign w_wrap = enable && (r_pre == DW'(BASE_DIV - 1));

  // Prescaler counter and registered base_tick pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre  <= '0;
      r_base <= 1'b0;
    end else if (enable) begin
      r_base <= w_wrap;
      r_pre  <= w_wrap ? DW'(0) : (r_pre + DW'(1));
    end else begin
      r_base <= 1'b0;
    end
  end

  // Config FSM next-state logic; ready/ack are registered from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = S_PEND;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PEND: begin
        // A frozen prescaler would never wrap, so apply straight away then.
        if (w_wrap || !enable) begin
          w_apply     = 1'b1;
          w_state_nxt = S_ACK;
        end else begin
          w_state_nxt = S_PEND;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config FSM state, handshake outputs and latched request.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_ack     <= 1'b0;
      r_lat_ch  <= '0;
      r_lat_per <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      r_ack   <= (w_state_nxt == S_ACK);
      if (w_latch) begin
        r_lat_ch  <= cfg_ch;
        r_lat_per <= cfg_period;
      end
    end
  end

  // Channel targeted by an apply this cycle; an out-of-range index matches none.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_apply && (r_lat_ch == CW'(i))) begin
        w_sel[i] = 1'b1;
      end else begin
        w_sel[i] = 1'b0;
      end
    end
  end

  // Per-channel period registers, counters and tick pulses.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        r_period[i] <= PW'(RST_PERIOD);
        r_cnt[i]    <= '0;
        r_tick[i]   <= 1'b0;
      end else begin
        r_tick[i] <= 1'b0;
        if (w_sel[i]) begin
          // New period counts from this edge; no tick here.
          r_period[i] <= r_lat_per;
          r_cnt[i]    <= '0;
        end else if (w_wrap) begin
          if (!ch_en[i] || (r_period[i] == PW'(0))) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] == (r_period[i] - PW'(1))) begin
            r_cnt[i]  <= '0;
            r_tick[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + PW'(1);
          end
        end
      end
    end
  end

  assign base_tick = r_base;
  assign tick      = r_tick;
  assign cfg_ready = r_ready;
  assign cfg_ack   = r_ack;

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

  localparam int BD = 4;
  localparam int NC = 4;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [NC-1:0] ch_en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [PW-1:0] cfg_period;
  logic          cfg_ack;
  logic          base_tick;
  logic [NC-1:0] tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: enabled-cycle count, per-channel base ticks since anchor.
  int            m_ecount;
  int            m_per   [NC];
  int            m_since [NC];
  bit            m_pend;
  int            m_pch;
  int            m_pper;
  bit            m_ack;
  bit            m_base;
  logic [NC-1:0] m_tick;
  int            m_accepts;

  tick_scheduler #(.BASE_DIV(BD), .NCH(NC), .PW(PW), .RST_PERIOD(0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .ch_en(ch_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_ack(cfg_ack), .base_tick(base_tick),
    .tick(tick)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs held now, then compare.
  task automatic cyc();
    bit wrap, apply, accept, rdy;
    rdy = !m_pend && !m_ack;
    m_tick = '0;
    if (reset) begin
      m_ecount = 0;
      for (int i = 0; i < NC; i++) begin
        m_per[i] = 0;
        m_since[i] = 0;
      end
      m_pend = 1'b0;
      m_ack  = 1'b0;
      m_base = 1'b0;
    end else begin
      wrap = enable && ((m_ecount % BD) == BD - 1);
      if (enable) m_ecount++;
      apply  = m_pend && (wrap || !enable);
      accept = cfg_valid && rdy;
      for (int i = 0; i < NC; i++) begin
        if (apply && m_pch == i) begin
          m_per[i]   = m_pper;
          m_since[i] = 0;
        end else if (wrap) begin
          if (!ch_en[i] || m_per[i] == 0) begin
            m_since[i] = 0;
          end else begin
            m_since[i]++;
            if ((m_since[i] % m_per[i]) == 0) m_tick[i] = 1'b1;
          end
        end
      end
      if (apply) m_pend = 1'b0;
      if (accept) begin
        m_pend = 1'b1;
        m_pch  = int'(cfg_ch);
        m_pper = int'(cfg_period);
        m_accepts++;
      end
      m_ack  = apply;
      m_base = wrap;
    end
    @(posedge clock);
    #1;
    check("base_tick", 32'(base_tick), 32'(m_base));
    check("tick", 32'(tick), 32'(m_tick));
    check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pend && !m_ack));
  endtask

  task automatic wait_base();
    int k;
    k = 0;
    while (!base_tick && k < BD + 2) begin
      cyc();
      k++;
    end
    check("wait_base", 32'(base_tick), 32'd1);
  endtask

  task automatic do_cfg(input int ch, input int per);
    int k;
    cfg_ch     = ch[1:0];
    cfg_period = per[PW-1:0];
    k = 0;
    while (!cfg_ready && k < 3 * BD + 4) begin
      cyc();
      k++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    k = 0;
    while (!cfg_ack && k < 3 * BD + 4) begin
      cyc();
      k++;
    end
    check("cfg_ack_seen", 32'(cfg_ack), 32'd1);
  endtask

  initial begin
    int k, cnt, first, second;
    m_accepts  = 0;
    reset      = 1'b1;
    enable     = 1'b0;
    ch_en      = '0;
    cfg_valid  = 1'b0;
    cfg_ch     = 2'd0;
    cfg_period = 4'd0;
    cyc();
    cyc();
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_tick", 32'(tick), 32'd0);

    // 1: base_tick every BD cycles, no channel ticks with zero periods.
    reset  = 1'b0;
    enable = 1'b1;
    ch_en  = 4'hF;
    cnt    = 0;
    for (int n = 0; n < 5 * BD; n++) begin
      cyc();
      if (base_tick) cnt++;
    end
    check("t1_base_count", 32'(cnt), 32'd5);

    // 2: ch0 = 3, ch1 = 1; tick[0] spacing is 3 base ticks.
    do_cfg(0, 3);
    do_cfg(1, 1);
    first  = -1;
    second = -1;
    for (int n = 0; n < 10 * BD; n++) begin
      cyc();
      if (tick[0]) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
    end
    check("t2_tick0_spacing", 32'(second - first), 32'(3 * BD));

    // 3: valid held through PEND; second request only after IDLE.
    m_accepts  = 0;
    cfg_ch     = 2'd2;
    cfg_period = 4'd2;
    cfg_valid  = 1'b1;
    k = 0;
    while (m_accepts < 1 && k < 20) begin
      cyc();
      k++;
    end
    cfg_ch     = 2'd3;
    cfg_period = 4'd5;
    k = 0;
    while (m_accepts < 2 && k < 40) begin
      cyc();
      k++;
    end
    cfg_valid = 1'b0;
    check("t3_second_accept", 32'(k < 40), 32'd1);
    k = 0;
    while (!cfg_ack && k < 3 * BD + 4) begin
      cyc();
      k++;
    end
    check("t3_ack2", 32'(cfg_ack), 32'd1);
    cnt = 0;
    for (int n = 0; n < 12 * BD; n++) begin
      cyc();
      if (tick[2] && tick[3]) cnt++;
    end
    check("t3_both_periods", 32'(cnt > 0), 32'd1);

    // 4: freeze mid-count, then resume after the remaining count.
    wait_base();
    cyc();
    enable = 1'b0;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (base_tick || (tick != '0)) cnt++;
    end
    check("t4_frozen_quiet", 32'(cnt), 32'd0);
    enable = 1'b1;
    first  = BD - (m_ecount % BD);
    k = 0;
    do begin
      cyc();
      k++;
    end while (!base_tick && k < 2 * BD);
    check("t4_resume_delay", 32'(k), 32'(first));

    // 5: ch_en[0] off across one wrap, back on -> tick after 3 base ticks.
    wait_base();
    ch_en[0] = 1'b0;
    for (int n = 0; n < BD; n++) cyc();
    ch_en[0] = 1'b1;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!tick[0] && k < 6 * BD);
    check("t5_reenable_delay", 32'(k), 32'(3 * BD));

    // 6: reset while PEND discards the request.
    wait_base();
    cfg_ch     = 2'd0;
    cfg_period = 4'd7;
    cfg_valid  = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    reset     = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    check("t6_ready_after_rst", 32'(cfg_ready), 32'd1);
    cnt = 0;
    for (int n = 0; n < 10 * BD; n++) begin
      cyc();
      if (cfg_ack || (tick != '0)) cnt++;
    end
    check("t6_silent_after_rst", 32'(cnt), 32'd0);

    // Random traffic against the model.
    ch_en = 4'hF;
    for (int n = 0; n < 1500; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom);
      cfg_period = 4'($urandom);
      reset      = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
